// File: rtl/rr_grant_scheduler.sv
// Four-way round-robin scheduler driving a registered one-hot select and its
// binary index; a hold counter caps each owner's tenure while others wait.
module rr_grant_scheduler #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    ptr, ptr_n;
    logic [1:0]    idx_n;
    logic [3:0]    grant_n;
    logic          valid_n;
    logic [3:0]    others;
    logic [1:0]    next_owner;

    // First set bit of mask, scanning start, start+1, ... with mod-4 wrap.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // grant is one-hot of the owner, so masking it out leaves the contenders.
    assign others     = req & ~grant;
    assign next_owner = rr_pick(others, grant_idx + 2'd1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        idx_n   = grant_idx;
        grant_n = grant;
        valid_n = grant_valid;
        case (state)
            IDLE: begin
                if (|req) begin
                    idx_n   = rr_pick(req, ptr);
                    grant_n = 4'b0001 << idx_n;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    ptr_n = grant_idx + 2'd1;
                    cnt_n = '0;
                    if (|others) begin
                        idx_n   = next_owner;
                        grant_n = 4'b0001 << next_owner;
                    end else begin
                        idx_n   = 2'd0;
                        grant_n = 4'b0000;
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (|others) begin
                        ptr_n   = grant_idx + 2'd1;
                        idx_n   = next_owner;
                        grant_n = 4'b0001 << next_owner;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= 2'd0;
            grant       <= 4'b0000;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ptr         <= ptr_n;
            grant       <= grant_n;
            grant_idx   <= idx_n;
            grant_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler with HOLD_CYCLES=4; expected grants
// are hand-derived from the round-robin and hold-counter rules.
module tb_rr_grant_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int checks   = 0;
    int failures = 0;

    rr_grant_scheduler #(.HOLD_CYCLES(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        checks++;
        if (grant !== 4'b0000 || grant_idx !== 2'd0 || grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_valid);
        end
        step();
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got %b/%b want 0000/0", grant, grant_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_grant();
        req = 4'b1010;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_grant_early got %b/%b want 0000/0", grant, grant_valid);
        end
        step();
        checks++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_grant got %b/%0d/%b want 0010/1/1", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_forced_rotation();
        // Owner 1 already holds for one cycle; three more before rotation.
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
                failures++;
                $display("FAIL hold_owner1 cyc=%0d got %b/%0d want 0010/1", i, grant, grant_idx);
            end
        end
        step();
        checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL rotate_to3 got %b/%0d/%b want 1000/3/1", grant, grant_idx, grant_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
                failures++;
                $display("FAIL hold_owner3 cyc=%0d got %b/%0d want 1000/3", i, grant, grant_idx);
            end
        end
        step();
        checks++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
            failures++;
            $display("FAIL rotate_back1 got %b/%0d want 0010/1", grant, grant_idx);
        end
    endtask

    task automatic test_single_requester();
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_take got %b/%0d/%b want 0100/2/1", grant, grant_idx, grant_valid);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
                failures++;
                $display("FAIL single_hold cyc=%0d got %b/%0d/%b want 0100/2/1", i, grant, grant_idx, grant_valid);
            end
        end
    endtask

    task automatic test_release_handover();
        req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            failures++;
            $display("FAIL owner0_take got %b/%0d want 0001/0", grant, grant_idx);
        end
        req = 4'b1010;
        step();
        checks++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL release_handover got %b/%0d/%b want 0010/1/1", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_all_drop();
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || grant_idx !== 2'd0 || grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL all_drop got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_valid);
        end
        req = 4'b1111;
        step();
        checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL idle_ptr_pick got %b/%0d/%b want 0100/2/1", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            failures++;
            $display("FAIL owner3_take got %b/%0d want 1000/3", grant, grant_idx);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_idx !== 2'd0 || grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_valid);
        end
        req = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_grant got %b/%0d/%b want 0001/0/1", grant, grant_idx, grant_valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_forced_rotation();
        test_single_requester();
        test_release_handover();
        test_all_drop();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one 2-to-4 decoded output resource (board LED bank / one-hot select) between four requesters.
- Registers a 2-bit owner index and its one-hot decode, so the downstream decoder path always sees a clean, glitch-free select.
- Bounds each owner's tenure with a hold counter, so no requester can starve the others.

Parameters:
- HOLD_CYCLES, 4, maximum consecutive cycles one owner keeps the grant while others are waiting; legal range 1..256.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately; deassertion is synchronised externally.
- req  input  4  request vector; req[i]=1 means requester i wants the resource; level-sensitive, sampled each rising edge.
- grant  output  4  registered one-hot grant; grant[i]=1 means requester i owns the resource; all-zero when idle.
- grant_idx  output  2  registered binary owner index; grant[grant_idx]=1 whenever grant_valid=1; 2'b00 when idle.
- grant_valid  output  1  registered; 1 while any grant is active.

Behaviour:
- Reset (rst_n=0, async):
  - grant=4'b0000, grant_idx=2'b00, grant_valid=0.
  - State=IDLE, hold counter=0, priority pointer ptr=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - If req!=0, select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load owner o into grant_idx, set grant to the decode of o, grant_valid=1, counter=0, go to GRANT.
  - Latency: req sampled at edge N; grant visible after edge N (one-cycle registered latency).
- State GRANT, owner o, evaluated each edge in priority order:
  1. req[o]=0 (release):
     - If any other req bit is set, hand over on this same edge to the first set bit searching o+1..o+3 (mod 4). No idle cycle; counter=0.
     - Otherwise go to IDLE with grant/grant_idx/grant_valid cleared.
     - In both cases ptr=o+1.
  2. req[o]=1 and counter==HOLD_CYCLES-1 and another req bit is set (forced rotation):
     - Hand over to the first set bit searching o+1..o+3; counter=0; ptr=o+1.
  3. req[o]=1 and counter==HOLD_CYCLES-1 and no other req bit is set:
     - Owner keeps the grant; counter wraps to 0.
  4. Otherwise: counter increments, outputs unchanged.
- Counter width is clog2(HOLD_CYCLES) with a minimum of 1 bit; it never exceeds HOLD_CYCLES-1.
- HOLD_CYCLES=1: with contention, ownership rotates every cycle.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_idx matches the set grant bit.
  - No output changes except on a clock edge or async reset.
- Simultaneous events:
  - Owner release and a new request in the same cycle: handover per rule 1. The new requester is eligible if it is first in the search.
  - Owner's own req is never the handover target on release.
- Reset mid-grant:
  - Outputs drop to zero asynchronously; ptr returns to 0.
  - After deassertion, the first grant follows IDLE arbitration from ptr=0.
- Requests of non-owners may toggle freely; only their value at the decision edge matters.

Test Plan:
- Reset then req=4'b1010:
  - Grant appears one edge later.
  - grant=4'b0010, grant_idx=1, grant_valid=1.
- Owner 1 holds req, req=4'b1010 steady, HOLD_CYCLES=4:
  - After 4 cycles of owner 1, grant=4'b1000 (idx 3).
  - After 4 more cycles, grant=4'b0010 again.
- Only req[2] high for 10 cycles:
  - grant=4'b0100 continuously; no gap at the counter wrap.
- Owner 0 drops req in the same cycle req[3] and req[1] are high:
  - Next edge grant=4'b0010 (idx 1, first after 0); grant_valid never drops.
- All requests drop:
  - Next edge grant=0, grant_idx=0, grant_valid=0.
  - Then req=4'b1111 yields owner ptr = last owner+1.
- rst_n pulsed low mid-grant (owner 3):
  - Outputs zero immediately, without waiting for clk.
  - After release with req=4'b1111, first grant is idx 0.
